// File: rtl/timer_pkg.sv
// Shared constants and types for the microwave timer keypad controller.
// Key codes, entry limits and the loader state encoding live here.
package timer_pkg;

    localparam logic [3:0] KEY_START    = 4'hA;
    localparam logic [3:0] KEY_CANCEL   = 4'hB;
    localparam int         MAX_DIGITS   = 4;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_LOAD,
        ST_RUN
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_entry_shifter.sv
// Four-digit BCD entry register with an accepted-digit counter.
// Digits shift in from the right; the caller gates shifting when full.
module bcd_entry_shifter
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       flush,
    input  logic       shift,
    input  logic [3:0] digit,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       full,
    output logic       all_zero,
    output logic       sec_invalid
);

    logic [2:0] count;

    // Shift register and digit counter; flush wins over shift.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            min_tens <= 4'h0;
            min_ones <= 4'h0;
            sec_tens <= 4'h0;
            sec_ones <= 4'h0;
            count    <= 3'd0;
        end else if (flush) begin
            min_tens <= 4'h0;
            min_ones <= 4'h0;
            sec_tens <= 4'h0;
            sec_ones <= 4'h0;
            count    <= 3'd0;
        end else if (shift) begin
            min_tens <= min_ones;
            min_ones <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= digit;
            count    <= count + 3'd1;
        end
    end

    assign full        = (count == 3'(MAX_DIGITS));
    assign all_zero    = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0);
    assign sec_invalid = (sec_tens > SEC_TENS_MAX);

endmodule

// File: rtl/time_entry_loader.sv
// Keypad-side controller: collects an MM:SS entry, validates it on START,
// loads the BCD down-counters and supervises the countdown.
module time_entry_loader
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       timer_zero,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       load,
    output logic       stop,
    output logic       timer_clear,
    output logic       done,
    output logic       err,
    output logic       busy
);

    state_t state;

    logic key_digit;
    logic key_start;
    logic key_cancel;
    logic entering;
    logic shift;
    logic flush;
    logic full;
    logic all_zero;
    logic sec_invalid;

    assign key_digit  = key_valid && is_digit(key_code);
    assign key_start  = key_valid && (key_code == KEY_START);
    assign key_cancel = key_valid && (key_code == KEY_CANCEL);

    assign entering = (state == ST_IDLE) || (state == ST_ENTRY);
    assign shift    = entering && key_digit && !full;

    // A countdown ending at zero clears the entry just like a cancel does.
    assign flush = ((state == ST_ENTRY) && key_cancel)
                || ((state == ST_RUN) && (timer_zero || key_cancel));

    bcd_entry_shifter u_shifter (
        .clk         (clk),
        .clear       (clear),
        .flush       (flush),
        .shift       (shift),
        .digit       (key_code),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .full        (full),
        .all_zero    (all_zero),
        .sec_invalid (sec_invalid)
    );

    // Counters hold whenever no countdown is loading or running.
    assign stop = entering;
    assign busy = !entering;

    // Loader FSM with one-cycle registered strobes.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state       <= ST_IDLE;
            load        <= 1'b0;
            timer_clear <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            load        <= 1'b0;
            timer_clear <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (key_digit) begin
                        state <= ST_ENTRY;
                    end else if (key_start) begin
                        err <= 1'b1;
                    end
                end
                ST_ENTRY: begin
                    if (key_cancel) begin
                        timer_clear <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (key_start) begin
                        if (sec_invalid || all_zero) begin
                            err <= 1'b1;
                        end else begin
                            load  <= 1'b1;
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (timer_zero) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else if (key_cancel) begin
                        timer_clear <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
